wb_stage: RTL and testbench

- Write-back stage of the 5-stage MIPS core. Consumes the MEM/WB pipeline register outputs and commits results: GPR write port, HI/LO register pair, CP0 write port.
- Performs load-data lane extraction and sign/zero extension from data SRAM.
- Holds the pipeline with a small FSM for uncached device (MMIO) loads whose data returns with variable latency.

---
 rtl/wb_stage_pkg.sv | 25 ++
 rtl/wb_stage_if.sv | 50 +++++
 rtl/wb_stage_load_align.sv | 34 +++
 rtl/wb_stage.sv | 114 +++++++++++
 tb/tb_wb_stage.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// Shared write-back definitions: load lane-select encodings, WB FSM states
// and zero constants used by the WB stage and the MEM-stage forwarding path.
package wb_stage_pkg;

    localparam int DRESEL_BUS = 5;

    // dre[3:0] lane patterns; dre[4] chooses zero (1) or sign (0) extension
    localparam logic [3:0] DRE_B0 = 4'b0001;
    localparam logic [3:0] DRE_B1 = 4'b0010;
    localparam logic [3:0] DRE_B2 = 4'b0100;
    localparam logic [3:0] DRE_B3 = 4'b1000;
    localparam logic [3:0] DRE_H0 = 4'b0011;
    localparam logic [3:0] DRE_H1 = 4'b1100;
    localparam logic [3:0] DRE_W  = 4'b1111;

    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [63:0] ZERO_DWORD = 64'h0000_0000_0000_0000;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_DEV = 2'd1,
        WB_COMMIT   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB pipeline register outputs, load return data and the commit ports
// of the write-back stage. The slave side is the WB stage itself.
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic [31:0]           wb_pc;
    logic [4:0]            wb_wa;
    logic                  wb_wreg;
    logic [31:0]           wb_dreg;
    logic                  wb_mreg;
    logic [DRESEL_BUS-1:0] wb_dre;
    logic                  wb_whilo;
    logic [63:0]           wb_hilo;
    logic                  wb_device;
    logic                  wb_cp0_we;
    logic [4:0]            wb_cp0_waddr;
    logic [31:0]           wb_cp0_wdata;
    logic [31:0]           dm_rdata;
    logic [31:0]           dev_rdata;
    logic                  dev_rvalid;

    logic                  rf_we;
    logic [4:0]            rf_wa;
    logic [31:0]           rf_wd;
    logic [31:0]           hi_o;
    logic [31:0]           lo_o;
    logic                  cp0_we;
    logic [4:0]            cp0_waddr;
    logic [31:0]           cp0_wdata;
    logic                  stall_req;
    logic                  dev_err;
    logic [31:0]           debug_wb_pc;

    modport master (
        output wb_pc, wb_wa, wb_wreg, wb_dreg, wb_mreg, wb_dre, wb_whilo, wb_hilo,
               wb_device, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata,
               dm_rdata, dev_rdata, dev_rvalid,
        input  rf_we, rf_wa, rf_wd, hi_o, lo_o, cp0_we, cp0_waddr, cp0_wdata,
               stall_req, dev_err, debug_wb_pc
    );

    modport slave (
        input  wb_pc, wb_wa, wb_wreg, wb_dreg, wb_mreg, wb_dre, wb_whilo, wb_hilo,
               wb_device, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata,
               dm_rdata, dev_rdata, dev_rvalid,
        output rf_we, rf_wa, rf_wd, hi_o, lo_o, cp0_we, cp0_waddr, cp0_wdata,
               stall_req, dev_err, debug_wb_pc
    );

endinterface

// File: rtl/wb_stage_load_align.sv
// Load-data lane extraction: right-justifies the selected byte/halfword/word
// of a read word and sign- or zero-extends it. Purely combinational.
module wb_stage_load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0]           src,
    input  logic [DRESEL_BUS-1:0] dre,
    output logic [31:0]           data
);

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic zext);
        return zext ? {24'h00_0000, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic zext);
        return zext ? {16'h0000, h} : {{16{h[15]}}, h};
    endfunction

    // Unlisted lane patterns (including no lanes at all) load zero
    always_comb begin
        data = ZERO_WORD;
        case (dre[3:0])
            DRE_W:   data = src;
            DRE_B0:  data = ext8(src[7:0],   dre[4]);
            DRE_B1:  data = ext8(src[15:8],  dre[4]);
            DRE_B2:  data = ext8(src[23:16], dre[4]);
            DRE_B3:  data = ext8(src[31:24], dre[4]);
            DRE_H0:  data = ext16(src[15:0],  dre[4]);
            DRE_H1:  data = ext16(src[31:16], dre[4]);
            default: data = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits GPR, HI/LO and CP0 results, and holds the pipeline
// while an uncached device load waits for its variable-latency data.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DEV_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       cpu_clk_50M,
    input  logic       cpu_rst,
    wb_stage_if.slave  bus
);

    wb_state_e   state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0] dev_buf;
    logic [31:0] hi_r, lo_r;
    logic        dev_err_r;
    logic        dev_load, timeout, hilo_we;
    logic        rf_we, cp0_we, stall;
    logic [31:0] commit_pc, align_src, align_data;

    assign dev_load  = bus.wb_mreg & bus.wb_device & bus.wb_wreg;
    assign timeout   = (wait_cnt == CNT_W'(DEV_TIMEOUT));
    assign align_src = (state == WB_COMMIT) ? dev_buf : bus.dm_rdata;

    wb_stage_load_align u_load_align (
        .src  (align_src),
        .dre  (bus.wb_dre),
        .data (align_data)
    );

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) state <= WB_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        rf_we     = 1'b0;
        cp0_we    = 1'b0;
        hilo_we   = 1'b0;
        commit_pc = ZERO_WORD;
        case (state)
            WB_IDLE: begin
                if (dev_load) begin
                    state_nxt = WB_WAIT_DEV;
                    stall     = 1'b1;
                end else begin
                    rf_we     = bus.wb_wreg;
                    cp0_we    = bus.wb_cp0_we;
                    hilo_we   = bus.wb_whilo;
                    commit_pc = bus.wb_pc;
                end
            end
            WB_WAIT_DEV: begin
                stall = 1'b1;
                if (bus.dev_rvalid || timeout) state_nxt = WB_COMMIT;
            end
            WB_COMMIT: begin
                rf_we     = 1'b1;
                commit_pc = bus.wb_pc;
                state_nxt = WB_IDLE;
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    // Returned data takes priority over a timeout landing in the same cycle
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            wait_cnt  <= '0;
            dev_buf   <= ZERO_WORD;
            dev_err_r <= 1'b0;
        end else begin
            dev_err_r <= (state == WB_WAIT_DEV) && timeout && !bus.dev_rvalid;
            if (state == WB_WAIT_DEV) begin
                if (bus.dev_rvalid) begin
                    dev_buf  <= bus.dev_rdata;
                    wait_cnt <= '0;
                end else if (timeout) begin
                    dev_buf  <= ZERO_WORD;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            {hi_r, lo_r} <= ZERO_DWORD;
        end else if (hilo_we) begin
            {hi_r, lo_r} <= bus.wb_hilo;
        end
    end

    assign bus.rf_we       = rf_we;
    assign bus.rf_wa       = bus.wb_wa;
    assign bus.rf_wd       = (bus.wb_mreg || state == WB_COMMIT) ? align_data : bus.wb_dreg;
    assign bus.hi_o        = hi_r;
    assign bus.lo_o        = lo_r;
    assign bus.cp0_we      = cp0_we;
    assign bus.cp0_waddr   = bus.wb_cp0_waddr;
    assign bus.cp0_wdata   = bus.wb_cp0_wdata;
    assign bus.stall_req   = stall;
    assign bus.dev_err     = dev_err_r;
    assign bus.debug_wb_pc = commit_pc;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a transaction-level commit queue plus a lane
// extraction model, checked every cycle, with literal checks pinning the model.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int T = 4;

    logic cpu_clk_50M = 1'b0;
    logic cpu_rst;
    always #5 cpu_clk_50M = ~cpu_clk_50M;

    wb_stage_if bus();

    wb_stage #(.DEV_TIMEOUT(T), .CNT_W(8)) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .bus         (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wa;
        logic        wreg;
        logic [31:0] dreg;
        logic        mreg;
        logic [4:0]  dre;
        logic        whilo;
        logic [63:0] hilo;
        logic        device;
        logic        cp0_we;
        logic [4:0]  cp0_waddr;
        logic [31:0] cp0_wdata;
        logic [31:0] dm;
    } ins_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        we;
        logic        cp0_we;
    } commit_t;

    commit_t     exp_q[$];
    commit_t     e_c;
    int          checks = 0;
    int          failures = 0;
    int          we_cnt = 0;
    int          err_cnt = 0;
    logic        chk_en = 1'b0;
    logic [31:0] hi_m = 32'h0, lo_m = 32'h0;
    logic        pend_whilo = 1'b0;
    logic [63:0] pend_hilo = 64'h0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    // Expected load result from lane rules: locate the selected lanes, shift, mask, extend
    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [4:0] dre);
        int n, lo_i;
        logic [31:0] v, mask;
        n = 0;
        lo_i = -1;
        for (int i = 0; i < 4; i++) begin
            if (dre[i]) begin
                n++;
                if (lo_i < 0) lo_i = i;
            end
        end
        if (n == 4) return w;
        if (!((n == 1) || (n == 2 && (lo_i == 0 || lo_i == 2) && dre[lo_i+1]))) return 32'h0;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (w >> (8 * lo_i)) & mask;
        if (!dre[4] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic ins_t nop();
        ins_t i;
        i.pc = 32'h0; i.wa = 5'd0; i.wreg = 1'b0; i.dreg = 32'h0; i.mreg = 1'b0;
        i.dre = 5'd0; i.whilo = 1'b0; i.hilo = 64'h0; i.device = 1'b0;
        i.cp0_we = 1'b0; i.cp0_waddr = 5'd0; i.cp0_wdata = 32'h0; i.dm = 32'h0;
        return i;
    endfunction

    task automatic drive(input ins_t i);
        bus.wb_pc = i.pc; bus.wb_wa = i.wa; bus.wb_wreg = i.wreg; bus.wb_dreg = i.dreg;
        bus.wb_mreg = i.mreg; bus.wb_dre = i.dre; bus.wb_whilo = i.whilo; bus.wb_hilo = i.hilo;
        bus.wb_device = i.device; bus.wb_cp0_we = i.cp0_we; bus.wb_cp0_waddr = i.cp0_waddr;
        bus.wb_cp0_wdata = i.cp0_wdata; bus.dm_rdata = i.dm;
    endtask

    task automatic step();
        @(posedge cpu_clk_50M);
        #1;
        if (pend_whilo) begin
            {hi_m, lo_m} = pend_hilo;
            pend_whilo = 1'b0;
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd,
                            input logic we, input logic cp0w);
        commit_t e;
        e.pc = pc; e.wa = wa; e.wd = wd; e.we = we; e.cp0_we = cp0w;
        exp_q.push_back(e);
    endtask

    // Single-cycle instruction (ALU, SRAM load, HI/LO, CP0, or bubble when pc == 0)
    task automatic issue(input ins_t i);
        step();
        drive(i);
        bus.dev_rvalid = 1'b0;
        if (i.pc != 32'h0)
            push_exp(i.pc, i.wa, i.mreg ? m_ext(i.dm, i.dre) : i.dreg, i.wreg, i.cp0_we);
        if (i.whilo) begin
            pend_whilo = 1'b1;
            pend_hilo  = i.hilo;
        end
        @(negedge cpu_clk_50M);
        #1;
        chk1("stall_idle", bus.stall_req, 1'b0);
        chk1("dev_err_idle", bus.dev_err, 1'b0);
    endtask

    // Device load: data pulses in wait cycle r (1-based), r == 0 means never
    task automatic dev_issue(input ins_t i, input int r, input logic [31:0] rdata,
                             input logic idle_pulse, output int stalls);
        logic ok;
        int   w;
        ok = (r != 0) && (r <= T + 1);
        w  = ok ? r : T + 1;
        stalls = 0;
        step();
        drive(i);
        bus.dev_rvalid = idle_pulse;
        bus.dev_rdata  = 32'hBAD0_BAD0;
        push_exp(i.pc, i.wa, m_ext(ok ? rdata : 32'h0, i.dre), 1'b1, 1'b0);
        for (int k = 0; k <= w; k++) begin
            @(negedge cpu_clk_50M);
            #1;
            chk1("stall_dev", bus.stall_req, 1'b1);
            chk1("dev_err_wait", bus.dev_err, 1'b0);
            if (bus.stall_req) stalls++;
            step();
            bus.dev_rvalid = (k + 1 == r);
            bus.dev_rdata  = (k + 1 == r) ? rdata : 32'hBAD0_BAD0;
        end
        @(negedge cpu_clk_50M);
        #1;
        chk1("stall_commit", bus.stall_req, 1'b0);
        chk1("dev_err_commit", bus.dev_err, !ok);
    endtask

    always @(negedge cpu_clk_50M) begin
        if (chk_en) begin
            if (bus.rf_we) we_cnt++;
            if (bus.dev_err) err_cnt++;
            chk1("we_without_pc", bus.rf_we && (bus.debug_wb_pc == 32'h0), 1'b0);
            chk32("hi_o", bus.hi_o, hi_m);
            chk32("lo_o", bus.lo_o, lo_m);
            if (bus.debug_wb_pc != 32'h0) begin
                if (exp_q.size() == 0) begin
                    chk32("unexpected_commit_pc", bus.debug_wb_pc, 32'h0);
                end else begin
                    e_c = exp_q.pop_front();
                    chk32("commit_pc", bus.debug_wb_pc, e_c.pc);
                    chk1("commit_rf_we", bus.rf_we, e_c.we);
                    chk1("commit_cp0_we", bus.cp0_we, e_c.cp0_we);
                    if (e_c.we) begin
                        chk32("commit_wa", {27'h0, bus.rf_wa}, {27'h0, e_c.wa});
                        chk32("commit_wd", bus.rf_wd, e_c.wd);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t i;
        int   st, wb0, eb0;
        logic [4:0] dres [9];
        dres = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b00011, 5'b01100,
                 5'b10011, 5'b11000, 5'b01111};

        drive(nop());
        bus.dev_rvalid = 1'b0;
        bus.dev_rdata  = 32'h0;
        cpu_rst = 1'b1;
        #3;
        chk32("rst_hi", bus.hi_o, 32'h0);
        chk32("rst_lo", bus.lo_o, 32'h0);
        chk1("rst_rf_we", bus.rf_we, 1'b0);
        chk1("rst_stall", bus.stall_req, 1'b0);
        chk1("rst_dev_err", bus.dev_err, 1'b0);
        @(posedge cpu_clk_50M);
        #1;
        cpu_rst = 1'b0;
        chk_en  = 1'b1;

        // SRAM loads from 0x1234_80FF
        i = nop(); i.wreg = 1'b1; i.mreg = 1'b1; i.wa = 5'd2; i.dm = 32'h1234_80FF;
        i.pc = 32'h100; i.dre = 5'b00010; issue(i);
        chk32("lb_lit", bus.rf_wd, 32'hFFFF_FF80);
        i.pc = 32'h104; i.dre = 5'b10010; issue(i);
        chk32("lbu_lit", bus.rf_wd, 32'h0000_0080);
        i.pc = 32'h108; i.dre = 5'b01100; issue(i);
        chk32("lh_lit", bus.rf_wd, 32'h0000_1234);
        i.pc = 32'h10C; i.dre = 5'b00000; issue(i);
        chk32("no_lane_lit", bus.rf_wd, 32'h0);
        for (int k = 0; k < 9; k++) begin
            i.pc = 32'h110 + 32'(4 * k); i.dre = dres[k]; i.dm = 32'h8765_80FF ^ 32'(k); issue(i);
        end

        // ALU result, HI/LO, CP0 and a write to r0
        i = nop(); i.pc = 32'h140; i.wreg = 1'b1; i.wa = 5'd4; i.dreg = 32'h55;
        i.whilo = 1'b1; i.hilo = 64'hDEAD_BEEF_0000_0001; issue(i);
        chk1("hilo_rf_we", bus.rf_we, 1'b1);
        issue(nop());
        chk32("hi_lit", bus.hi_o, 32'hDEAD_BEEF);
        chk32("lo_lit", bus.lo_o, 32'h0000_0001);
        i = nop(); i.pc = 32'h144; i.cp0_we = 1'b1; i.cp0_waddr = 5'd12; i.cp0_wdata = 32'hA5A5_0F0F; issue(i);
        chk32("cp0_wdata_lit", bus.cp0_wdata, 32'hA5A5_0F0F);
        i = nop(); i.pc = 32'h148; i.wreg = 1'b1; i.wa = 5'd0; i.dreg = 32'h99; issue(i);

        // Device load answered in wait cycle 3, then back-to-back ALU op
        wb0 = we_cnt;
        i = nop(); i.pc = 32'h200; i.wreg = 1'b1; i.mreg = 1'b1; i.device = 1'b1;
        i.wa = 5'd6; i.dre = 5'b01111; i.dm = 32'h1111_1111;
        dev_issue(i, 3, 32'hCAFE_0001, 1'b0, st);
        chk32("dev_stall_cycles", 32'(st), 32'd4);
        chk32("dev_wd_lit", bus.rf_wd, 32'hCAFE_0001);
        chk32("dev_pc_lit", bus.debug_wb_pc, 32'h200);
        chk32("dev_one_write", 32'(we_cnt - wb0), 32'd1);
        i = nop(); i.pc = 32'h204; i.wreg = 1'b1; i.wa = 5'd3; i.dreg = 32'h7; issue(i);
        chk32("b2b_wa", {27'h0, bus.rf_wa}, 32'd3);
        chk32("b2b_wd", bus.rf_wd, 32'h7);

        // Timeout with no data, then data arriving on the timeout cycle
        eb0 = err_cnt;
        i = nop(); i.pc = 32'h300; i.wreg = 1'b1; i.mreg = 1'b1; i.device = 1'b1;
        i.wa = 5'd7; i.dre = 5'b01111;
        dev_issue(i, 0, 32'h0, 1'b0, st);
        chk32("to_wd_lit", bus.rf_wd, 32'h0);
        chk32("to_stall_cycles", 32'(st), 32'(T + 2));
        i = nop(); i.pc = 32'h304; i.wreg = 1'b1; i.wa = 5'd8; i.dreg = 32'h8; issue(i);
        chk32("to_one_err", 32'(err_cnt - eb0), 32'd1);
        i = nop(); i.pc = 32'h308; i.wreg = 1'b1; i.mreg = 1'b1; i.device = 1'b1;
        i.wa = 5'd9; i.dre = 5'b01111;
        dev_issue(i, T + 1, 32'h0BAD_F00D, 1'b0, st);
        chk32("race_wd_lit", bus.rf_wd, 32'h0BAD_F00D);
        // Pulse during the IDLE cycle is ignored; halfword zero-extended from real data
        i.pc = 32'h30C; i.dre = 5'b11100;
        dev_issue(i, 2, 32'h9ABC_0000, 1'b1, st);
        chk32("dev_lhu_lit", bus.rf_wd, 32'h0000_9ABC);
        issue(nop());

        // Reset during WAIT_DEV aborts the load; a late dev_rvalid is ignored
        i = nop(); i.pc = 32'h400; i.wreg = 1'b1; i.mreg = 1'b1; i.device = 1'b1;
        i.wa = 5'd10; i.dre = 5'b01111;
        step(); drive(i); bus.dev_rvalid = 1'b0;
        step();
        @(negedge cpu_clk_50M);
        #2;
        chk_en = 1'b0;
        cpu_rst = 1'b1;
        drive(nop());
        #1;
        chk32("mid_rst_hi", bus.hi_o, 32'h0);
        chk32("mid_rst_lo", bus.lo_o, 32'h0);
        chk1("mid_rst_rf_we", bus.rf_we, 1'b0);
        chk1("mid_rst_stall", bus.stall_req, 1'b0);
        hi_m = 32'h0; lo_m = 32'h0; pend_whilo = 1'b0;
        @(posedge cpu_clk_50M);
        #1;
        cpu_rst = 1'b0;
        bus.dev_rvalid = 1'b1;
        bus.dev_rdata  = 32'h1234_5678;
        chk_en = 1'b1;
        @(negedge cpu_clk_50M);
        #1;
        chk1("late_rvalid_stall", bus.stall_req, 1'b0);
        chk32("late_rvalid_pc", bus.debug_wb_pc, 32'h0);
        i = nop(); i.pc = 32'h404; i.wreg = 1'b1; i.wa = 5'd11; i.dreg = 32'h11; issue(i);
        issue(nop());

        chk32("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
